// File: rtl/pipe_cpu_pkg.sv
// Shared encodings, ALU operation set and pipeline-register layouts
// for the five-stage pipe_cpu core.
package pipe_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  // rd holds the destination register (rt for I-type writers)
  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [31:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] st_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } mem_wb_t;

endpackage

// File: rtl/pipe_cpu_if.sv
// Register-file access bus: two read ports for ID, one write port for WB.
interface pipe_cpu_if;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output rs_addr, rt_addr, we, wr_addr, wr_data,
                  input  rs_data, rt_data);
  modport slave  (input  rs_addr, rt_addr, we, wr_addr, wr_data,
                  output rs_data, rt_data);
endinterface

// File: rtl/pipe_cpu_imem.sv
// Instruction memory: combinational read, contents loaded from outside, never reset.
module pipe_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   data_o
);
  logic [31:0] Instr_Mem [0:DEPTH-1];

  assign data_o = Instr_Mem[addr_i];
endmodule

// File: rtl/pipe_cpu_regfile.sv
// 32x32 register file; $0 is hardwired to zero and a same-cycle write bypasses to the read ports.
module pipe_regfile (
  input logic        clk_i,
  input logic        rst_i,
  pipe_cpu_if.slave  bus
);
  logic [31:0] Reg_File [0:31];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
    end else if (bus.we && bus.wr_addr != 5'd0) begin
      Reg_File[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    bus.rs_data = Reg_File[bus.rs_addr];
    bus.rt_data = Reg_File[bus.rt_addr];
    if (bus.we && bus.wr_addr == bus.rs_addr) bus.rs_data = bus.wr_data;
    if (bus.we && bus.wr_addr == bus.rt_addr) bus.rt_data = bus.wr_data;
    if (bus.rs_addr == 5'd0) bus.rs_data = '0;
    if (bus.rt_addr == 5'd0) bus.rt_data = '0;
  end
endmodule

// File: rtl/pipe_cpu.sv
// Five-stage in-order MIPS-subset core with forwarding, load-use stall and
// EX-resolved BEQ; instruction and data memories are internal.
module pipe_cpu
  import pipe_cpu_pkg::*;
#(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 128
) (
  input logic clk_i,
  input logic rst_i
);
  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d, dec;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic [31:0] dmem_q [DM_DEPTH];

  logic [31:0] instr_f;
  logic [5:0]  id_op, id_fn;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall, br_taken;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res, br_target;
  logic [DM_AW-1:0] dm_idx;

  pipe_cpu_if rf_bus ();

  pipe_imem #(.DEPTH(IM_DEPTH)) IM (.addr_i(pc_q[IM_AW+1:2]), .data_o(instr_f));
  pipe_regfile RF (.clk_i(clk_i), .rst_i(rst_i), .bus(rf_bus));

  assign id_op = if_id_q.instr[31:26];
  assign id_rs = if_id_q.instr[25:21];
  assign id_rt = if_id_q.instr[20:16];
  assign id_rd = if_id_q.instr[15:11];
  assign id_fn = if_id_q.instr[5:0];

  assign rf_bus.rs_addr = id_rs;
  assign rf_bus.rt_addr = id_rt;
  assign rf_bus.we      = mem_wb_q.reg_write;
  assign rf_bus.wr_addr = mem_wb_q.rd;
  assign rf_bus.wr_data = mem_wb_q.wdata;

  // Unsupported opcodes/functs leave every control bit clear, i.e. a NOP
  always_comb begin
    dec        = '0;
    dec.rs     = id_rs;
    dec.rt     = id_rt;
    dec.rs_val = rf_bus.rs_data;
    dec.rt_val = rf_bus.rt_data;
    dec.imm    = {{16{if_id_q.instr[15]}}, if_id_q.instr[15:0]};
    dec.pc4    = if_id_q.pc4;
    case (id_op)
      OP_RTYPE: begin
        dec.rd        = id_rd;
        dec.reg_write = 1'b1;
        case (id_fn)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: dec.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.rd = id_rt; end
      OP_LW:   begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1; dec.rd = id_rt; end
      OP_SW:   begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      OP_BEQ:  begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; end
      default: ;
    endcase
  end

  assign stall = id_ex_q.mem_read && id_ex_q.rd != 5'd0 &&
                 (id_ex_q.rd == id_rs || id_ex_q.rd == id_rt);

  always_comb begin
    fwd_a = id_ex_q.rs_val;
    if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs)
      fwd_a = ex_mem_q.alu_res;
    else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs)
      fwd_a = mem_wb_q.wdata;
    fwd_b = id_ex_q.rt_val;
    if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rt)
      fwd_b = ex_mem_q.alu_res;
    else if (mem_wb_q.reg_write && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rt)
      fwd_b = mem_wb_q.wdata;
  end

  assign alu_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;

  always_comb begin
    case (id_ex_q.alu_op)
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_res = fwd_a + alu_b;
    endcase
  end

  assign br_taken  = id_ex_q.branch && (fwd_a == fwd_b);
  assign br_target = id_ex_q.pc4 + {id_ex_q.imm[29:0], 2'b00};
  assign dm_idx    = ex_mem_q.alu_res[DM_AW+1:2];

  always_comb begin
    ex_mem_d.reg_write = id_ex_q.reg_write;
    ex_mem_d.mem_read  = id_ex_q.mem_read;
    ex_mem_d.mem_write = id_ex_q.mem_write;
    ex_mem_d.rd        = id_ex_q.rd;
    ex_mem_d.alu_res   = alu_res;
    ex_mem_d.st_data   = fwd_b;

    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.rd        = ex_mem_q.rd;
    mem_wb_d.wdata     = ex_mem_q.mem_read ? dmem_q[dm_idx] : ex_mem_q.alu_res;
  end

  // A taken branch overrides a coincident load-use stall
  always_comb begin
    pc_d          = pc_q + 32'd4;
    if_id_d.pc4   = pc_q + 32'd4;
    if_id_d.instr = instr_f;
    id_ex_d       = dec;
    if (br_taken) begin
      pc_d    = br_target;
      if_id_d = '0;
      id_ex_d = '0;
    end else if (stall) begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      for (int i = 0; i < DM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      if (ex_mem_q.mem_write) dmem_q[dm_idx] <= ex_mem_q.st_data;
    end
  end
endmodule

// File: tb/tb_pipe_cpu.sv
// Directed bench for pipe_cpu: short programs loaded into IM, register/memory state checked afterwards.
module tb_pipe_cpu;
  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;
  logic [31:0] prog [$];

  pipe_cpu #(.IM_DEPTH(256), .DM_DEPTH(128)) dut (.clk_i(clk_i), .rst_i(rst_i));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.IM.Instr_Mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.IM.Instr_Mem[i] = prog[i];
  endtask

  // Hold reset across a load, release on a falling edge; the next rising edge ends cycle 0
  task automatic start();
    rst_i = 1'b1;
    @(negedge clk_i);
    load_prog();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rf(input int r);
    return dut.RF.Reg_File[r];
  endfunction

  function automatic logic [31:0] nz_regs();
    logic [31:0] n = 0;
    for (int r = 0; r < 32; r++) if (dut.RF.Reg_File[r] !== 32'h0) n++;
    return n;
  endfunction

  function automatic logic [31:0] nz_dmem();
    logic [31:0] n = 0;
    for (int i = 0; i < 128; i++) if (dut.dmem_q[i] !== 32'h0) n++;
    return n;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("reset_pc", dut.pc_q, 32'h0);
    chk("reset_regs_nonzero", nz_regs(), 32'd0);
    chk("reset_dmem_nonzero", nz_dmem(), 32'd0);
    chk("reset_idex_regwrite", {31'd0, dut.id_ex_q.reg_write}, 32'd0);

    // independent ops
    prog = '{itype(6'h08, 0, 1, 16'd5), itype(6'h08, 0, 2, 16'd7), rtype(6'h20, 1, 2, 3)};
    start();
    cycles(10);
    chk("t1_r1", rf(1), 32'd5);
    chk("t1_r2", rf(2), 32'd7);
    chk("t1_r3", rf(3), 32'd12);
    chk("t1_other_nonzero", nz_regs(), 32'd3);

    // back-to-back forwarding; slt (4th word) must retire on the 8th edge
    prog = '{itype(6'h08, 0, 1, 16'd3), rtype(6'h22, 1, 1, 2),
             rtype(6'h25, 1, 2, 3), rtype(6'h2A, 2, 1, 4)};
    start();
    cycles(7);
    chk("t2_r4_before", rf(4), 32'd0);
    cycles(1);
    chk("t2_r4_at8", rf(4), 32'd1);
    cycles(4);
    chk("t2_r2", rf(2), 32'd0);
    chk("t2_r3", rf(3), 32'd3);

    // store / load / load-use stall: add retires on edge 9 instead of 8
    prog = '{itype(6'h08, 0, 1, 16'hFFF7), itype(6'h2B, 0, 1, 16'd8),
             itype(6'h23, 0, 2, 16'd8), rtype(6'h20, 2, 2, 3)};
    start();
    cycles(8);
    chk("t3_r3_before", rf(3), 32'd0);
    cycles(1);
    chk("t3_r3_at9", rf(3), 32'hFFFF_FFEE);
    cycles(4);
    chk("t3_r1", rf(1), 32'hFFFF_FFF7);
    chk("t3_r2", rf(2), 32'hFFFF_FFF7);
    chk("t3_dmem2", dut.dmem_q[2], 32'hFFFF_FFF7);

    // taken branch skips two words
    prog = '{itype(6'h08, 0, 1, 16'd1), itype(6'h04, 1, 1, 16'd2), itype(6'h08, 0, 5, 16'd9),
             itype(6'h08, 0, 6, 16'd9), itype(6'h08, 0, 7, 16'd4)};
    start();
    cycles(14);
    chk("t4_r5", rf(5), 32'd0);
    chk("t4_r6", rf(6), 32'd0);
    chk("t4_r7", rf(7), 32'd4);

    // not-taken branch falls through
    prog = '{itype(6'h08, 0, 1, 16'd1), itype(6'h04, 1, 0, 16'd2), itype(6'h08, 0, 5, 16'd9),
             itype(6'h08, 0, 6, 16'd9), itype(6'h08, 0, 7, 16'd4)};
    start();
    cycles(14);
    chk("t5_r5", rf(5), 32'd9);
    chk("t5_r6", rf(6), 32'd9);
    chk("t5_r7", rf(7), 32'd4);

    // $0 protection and NOP-like words (unsupported funct 0x27, unsupported opcode 0x0D)
    prog = '{itype(6'h08, 0, 0, 16'd5), rtype(6'h20, 0, 0, 1), 32'h0,
             rtype(6'h27, 0, 0, 8), itype(6'h0D, 0, 9, 16'h00FF), 32'h0};
    start();
    cycles(14);
    chk("t6_r0", rf(0), 32'd0);
    chk("t6_r1", rf(1), 32'd0);
    chk("t6_r8", rf(8), 32'd0);
    chk("t6_r9", rf(9), 32'd0);
    chk("t6_dmem_nonzero", nz_dmem(), 32'd0);

    // asynchronous reset mid-run, then re-execution from PC 0
    prog = '{itype(6'h08, 0, 1, 16'hFFF7), itype(6'h2B, 0, 1, 16'd8),
             itype(6'h23, 0, 2, 16'd8), rtype(6'h20, 2, 2, 3)};
    start();
    cycles(5);
    chk("t7_r1_prereset", rf(1), 32'hFFFF_FFF7);
    #1;
    rst_i = 1'b1;
    #1;
    chk("t7_pc_async", dut.pc_q, 32'h0);
    chk("t7_regs_async", nz_regs(), 32'd0);
    chk("t7_dmem_async", nz_dmem(), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    cycles(14);
    chk("t7_r1", rf(1), 32'hFFFF_FFF7);
    chk("t7_r2", rf(2), 32'hFFFF_FFF7);
    chk("t7_r3", rf(3), 32'hFFFF_FFEE);
    chk("t7_dmem2", dut.dmem_q[2], 32'hFFFF_FFF7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
